// File: rtl/regfile_dump_ctrl_if.sv
// ============================================================================
// regfile_dump_ctrl_if : regfile ports and dump stream of regfile_dump_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface regfile_dump_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic              clear_req;
  logic [ADDR_W-1:0] rd_reg;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, clear_req, rd_data, dump_ready,
    output rd_reg, wr_reg, wr_data, wr_en, dump_valid, dump_addr, dump_data, busy, done
  );

  modport slave (
    output start, clear_req, rd_data, dump_ready,
    input  rd_reg, wr_reg, wr_data, wr_en, dump_valid, dump_addr, dump_data, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/regfile_dump_ctrl.sv
// ============================================================================
// regfile_dump_ctrl : walks regfile read port 1 and streams (addr, data) beats;
//                     optional post-dump clear when REGFILE_DUMP_CLEAR_EN is defined
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_dump_ctrl #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int START_REG = 0
) (
  input wire               clk,
  input wire               areset,
  regfile_dump_ctrl_if.master bus
);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_READ  = 3'd1;
  localparam logic [2:0] c_S_HOLD  = 3'd2;
`ifdef REGFILE_DUMP_CLEAR_EN
  localparam logic [2:0] c_S_CLEAR = 3'd3;
`endif
  localparam logic [2:0] c_S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] c_START = ADDR_W'(START_REG);
  localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] c_ONE   = ADDR_W'(1);

  generate
    if (START_REG >= NUM_REGS) begin : g_bad_start_reg
      $error("regfile_dump_ctrl: START_REG must be below NUM_REGS");
    end
    if (NUM_REGS > (1 << ADDR_W)) begin : g_bad_num_regs
      $error("regfile_dump_ctrl: NUM_REGS does not fit in ADDR_W bits");
    end
  endgenerate

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rd_reg;
  logic              r_dump_valid;
  logic [ADDR_W-1:0] r_dump_addr;
  logic [DATA_W-1:0] r_dump_data;
  logic              r_done;
  logic [ADDR_W-1:0] w_addr_nxt;

  assign w_addr_nxt = r_addr + c_ONE;

`ifdef REGFILE_DUMP_CLEAR_EN
  // A single-register file has nothing to clear: register 0 is never written.
  localparam bit c_HAS_CLR = (NUM_REGS > 1);

  logic              r_clr_flag;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_reg;
`else
  logic              w_unused_clear_req;
  assign w_unused_clear_req = bus.clear_req;
`endif

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state      <= c_S_IDLE;
      r_addr       <= '0;
      r_rd_reg     <= '0;
      r_dump_valid <= 1'b0;
      r_dump_addr  <= '0;
      r_dump_data  <= '0;
      r_done       <= 1'b0;
`ifdef REGFILE_DUMP_CLEAR_EN
      r_clr_flag   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_reg     <= '0;
`endif
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (bus.start) begin
            r_addr   <= c_START;
            r_rd_reg <= c_START;
`ifdef REGFILE_DUMP_CLEAR_EN
            r_clr_flag <= bus.clear_req;
`endif
            r_state  <= c_S_READ;
          end
        end
        c_S_READ: begin
          r_dump_data  <= bus.rd_data;
          r_dump_addr  <= r_addr;
          r_dump_valid <= 1'b1;
          r_state      <= c_S_HOLD;
        end
        c_S_HOLD: begin
          if (bus.dump_ready) begin
            r_dump_valid <= 1'b0;
            if (r_addr == c_LAST) begin
`ifdef REGFILE_DUMP_CLEAR_EN
              if (r_clr_flag && c_HAS_CLR) begin
                r_wr_en  <= 1'b1;
                r_wr_reg <= c_ONE;
                r_state  <= c_S_CLEAR;
              end else
`endif
              begin
                r_done  <= 1'b1;
                r_state <= c_S_DONE;
              end
            end else begin
              r_addr   <= w_addr_nxt;
              r_rd_reg <= w_addr_nxt;
              r_state  <= c_S_READ;
            end
          end
        end
`ifdef REGFILE_DUMP_CLEAR_EN
        c_S_CLEAR: begin
          if (r_wr_reg == c_LAST) begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b1;
            r_state <= c_S_DONE;
          end else begin
            r_wr_reg <= r_wr_reg + c_ONE;
          end
        end
`endif
        c_S_DONE: begin
          r_done  <= 1'b0;
          r_state <= c_S_IDLE;
        end
        default: begin
          r_dump_valid <= 1'b0;
          r_done       <= 1'b0;
          r_state      <= c_S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_reg     = r_rd_reg;
  assign bus.dump_valid = r_dump_valid;
  assign bus.dump_addr  = r_dump_addr;
  assign bus.dump_data  = r_dump_data;
  assign bus.done       = r_done;
  assign bus.busy       = (r_state != c_S_IDLE);
  assign bus.wr_data    = '0;
`ifdef REGFILE_DUMP_CLEAR_EN
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_reg     = r_wr_reg;
`else
  assign bus.wr_en      = 1'b0;
  assign bus.wr_reg     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_ctrl.sv
// ============================================================================
// tb_regfile_dump_ctrl : directed/randomized bench with a queue-based beat model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_dump_ctrl;

  localparam int c_N = 32;
`ifdef REGFILE_DUMP_CLEAR_EN
  localparam bit c_CLR_EN = 1'b1;
`else
  localparam bit c_CLR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        areset;
  logic        start;
  logic        clear_req;
  logic        dump_ready;
  logic        sel;
  logic        load;
  logic [31:0] rf  [c_N];
  logic [31:0] mdl [c_N];
  int          n_vec = 0;
  int          n_err = 0;

  regfile_dump_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus0 ();
  regfile_dump_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus1 ();

  regfile_dump_ctrl #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .START_REG(0)) u_dut0 (
    .clk(clk), .areset(areset), .bus(bus0)
  );
  regfile_dump_ctrl #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .START_REG(30)) u_dut1 (
    .clk(clk), .areset(areset), .bus(bus1)
  );

  always #5 clk = ~clk;

  assign bus0.start      = start & ~sel;
  assign bus1.start      = start & sel;
  assign bus0.clear_req  = clear_req;
  assign bus1.clear_req  = clear_req;
  assign bus0.dump_ready = dump_ready;
  assign bus1.dump_ready = dump_ready;
  assign bus0.rd_data    = rf[bus0.rd_reg];
  assign bus1.rd_data    = rf[bus1.rd_reg];

  // Register file storage; only the START_REG=0 instance may write it.
  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < c_N; k++) rf[k] <= 32'(k) * 32'h01010101;
    end else if (bus0.wr_en) begin
      rf[bus0.wr_reg] <= bus0.wr_data;
    end
  end

  logic        m_valid, m_done, m_busy, m_wr_en;
  logic [4:0]  m_addr, m_wr_reg;
  logic [31:0] m_data, m_wr_data;
  assign m_valid   = sel ? bus1.dump_valid : bus0.dump_valid;
  assign m_done    = sel ? bus1.done       : bus0.done;
  assign m_busy    = sel ? bus1.busy       : bus0.busy;
  assign m_wr_en   = sel ? bus1.wr_en      : bus0.wr_en;
  assign m_addr    = sel ? bus1.dump_addr  : bus0.dump_addr;
  assign m_wr_reg  = sel ? bus1.wr_reg     : bus0.wr_reg;
  assign m_data    = sel ? bus1.dump_data  : bus0.dump_data;
  assign m_wr_data = sel ? bus1.wr_data    : bus0.wr_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete dump from start to idle, checked against a queue of expected beats.
  task automatic run_dump(input int sreg, input bit rnd, input bit clr, input bit spam);
    logic [4:0]  qa[$];
    logic [31:0] qd[$];
    logic [4:0]  ha;
    logic [31:0] hd;
    int cyc = 0, nbeats = 0, nwr = 0, last_acc = -1, first_v = -1, exp_wr = 1, done_lat;
    bit held = 1'b0, fin = 1'b0;
    for (int k = sreg; k < c_N; k++) begin
      qa.push_back(5'(k));
      qd.push_back(mdl[k]);
    end
    done_lat = (clr && c_CLR_EN) ? c_N : 1;
    @(negedge clk);
    start      = 1'b1;
    clear_req  = clr;
    dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!fin && cyc < 600) begin
      @(negedge clk);
      cyc++;
      start      = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      clear_req  = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("busy", m_busy, 1);
      if (held) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_addr", m_addr, ha);
        chk("hold_data", m_data, hd);
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && dump_ready) begin
        if (qa.size() == 0) begin
          chk("extra_beat", nbeats, c_N - sreg - 1);
        end else begin
          chk("beat_addr", m_addr, qa.pop_front());
          chk("beat_data", m_data, qd.pop_front());
        end
        nbeats++;
        last_acc = cyc;
        held = 1'b0;
      end else begin
        held = m_valid;
        ha   = m_addr;
        hd   = m_data;
      end
      if (m_wr_en) begin
        chk("wr_reg", m_wr_reg, exp_wr);
        chk("wr_data", m_wr_data, 0);
        chk("wr_after_beats", nbeats, c_N - sreg);
        exp_wr++;
        nwr++;
      end
      if (m_done) begin
        chk("done_latency", cyc, last_acc + done_lat);
        fin       = 1'b1;
        start     = 1'b0;
        clear_req = 1'b0;
      end
    end
    chk("finished", fin, 1);
    chk("beat_count", nbeats, c_N - sreg);
    @(negedge clk);
    chk("done_width", m_done, 0);
    chk("idle_busy", m_busy, 0);
    chk("idle_valid", m_valid, 0);
    chk("wr_count", nwr, (clr && c_CLR_EN) ? c_N - 1 : 0);
    if (!rnd) begin
      chk("first_valid", first_v, 2);
      chk("beat_rate", last_acc - first_v, 2 * (nbeats - 1));
    end
    @(negedge clk);
    chk("no_retrigger", m_busy, 0);
    if (clr && c_CLR_EN) begin
      for (int k = 1; k < c_N; k++) mdl[k] = 32'h0;
    end
  endtask

  initial begin
    bit found;
    areset     = 1'b1;
    start      = 1'b0;
    clear_req  = 1'b0;
    dump_ready = 1'b0;
    sel        = 1'b0;
    load       = 1'b1;
    for (int k = 0; k < c_N; k++) mdl[k] = 32'(k) * 32'h01010101;
    repeat (2) @(negedge clk);
    load = 1'b0;

    chk("rst_rd_reg", bus0.rd_reg, 0);
    chk("rst_wr_reg", bus0.wr_reg, 0);
    chk("rst_wr_data", bus0.wr_data, 0);
    chk("rst_wr_en", bus0.wr_en, 0);
    chk("rst_valid", bus0.dump_valid, 0);
    chk("rst_addr", bus0.dump_addr, 0);
    chk("rst_data", bus0.dump_data, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_busy1", bus1.busy, 0);
    @(negedge clk);
    areset = 1'b0;

    // Full-rate dump, then random backpressure, then start spammed while busy.
    run_dump(0, 1'b0, 1'b0, 1'b0);
    run_dump(0, 1'b1, 1'b0, 1'b0);
    run_dump(0, 1'b0, 1'b0, 1'b1);

    // Abort while holding the beat for register 0x0C.
    @(negedge clk);
    start      = 1'b1;
    dump_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (bus0.dump_valid && bus0.dump_addr == 5'h0C) begin
        dump_ready = 1'b0;
        found      = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("abort_reach", found, 1);
    @(negedge clk);
    chk("abort_hold_valid", bus0.dump_valid, 1);
    chk("abort_hold_addr", bus0.dump_addr, 5'h0C);
    #1 areset = 1'b1;
    #1;
    chk("abort_valid", bus0.dump_valid, 0);
    chk("abort_addr", bus0.dump_addr, 0);
    chk("abort_data", bus0.dump_data, 0);
    chk("abort_rd_reg", bus0.rd_reg, 0);
    chk("abort_busy", bus0.busy, 0);
    @(negedge clk);
    areset = 1'b0;
    run_dump(0, 1'b1, 1'b0, 1'b0);

    // Dump with clear request, then a follow-up dump reflecting the clear.
    run_dump(0, 1'b1, 1'b1, 1'b0);
    run_dump(0, 1'b0, 1'b0, 1'b0);

    // START_REG=30 instance: two beats only.
    sel = 1'b1;
    run_dump(30, 1'b0, 1'b0, 1'b0);
    run_dump(30, 1'b1, 1'b0, 1'b0);
    sel = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
